// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: default register-number
// width, hazard/recovery FSM encoding and the scoreboard entry layout.
package pipe_pkg;

  // Default width of a register number.
  localparam int REGNOBITS_DEF = 6;

  // Widest register number a scoreboard entry can hold; narrower register
  // numbers are zero-extended into the entry.
  localparam int REGNO_MAX = 16;

  // Control FSM: normal issue, or holding flush_D after a mispredict.
  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  // One in-flight register write between decode and register-file write.
  typedef struct packed {
    logic                 valid;
    logic [REGNO_MAX-1:0] regno;
  } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight write scoreboard: a shift register of {valid, regno} advanced
// every cycle (entry 0 youngest), plus combinational source-operand matching.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int REGNOBITS = REGNOBITS_DEF,
  parameter int SBDEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_ins_valid,
  input  logic [REGNOBITS-1:0] i_wregno,
  input  logic                 i_use_rs,
  input  logic [REGNOBITS-1:0] i_rs,
  input  logic                 i_use_rt,
  input  logic [REGNOBITS-1:0] i_rt,
  output logic                 o_hazard,
  output logic                 o_busy
);

  sb_entry_t r_sb [SBDEPTH];
  logic      w_match_rs;
  logic      w_match_rt;

  // Shift the scoreboard every cycle; stalled cycles push bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this array is a few flops, not a RAM, so it can take the async
      // reset; clearing the whole entry keeps the reset value unambiguous.
      for (int i = 0; i < SBDEPTH; i++) r_sb[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every entry load its neighbour's
      // old value, which is exactly the shift; blocking would smear entry 0.
      r_sb[0] <= '{valid: i_ins_valid, regno: REGNO_MAX'(i_wregno)};
      for (int i = 1; i < SBDEPTH; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  // Compare both source registers against every valid in-flight write.
  always_comb begin
    // NOTE: defaults first, so no path through the loop can infer a latch.
    w_match_rs = 1'b0;
    w_match_rt = 1'b0;
    o_busy     = 1'b0;
    for (int i = 0; i < SBDEPTH; i++) begin
      if (r_sb[i].valid) begin
        o_busy = 1'b1;
        if (r_sb[i].regno == REGNO_MAX'(i_rs)) w_match_rs = 1'b1;
        if (r_sb[i].regno == REGNO_MAX'(i_rt)) w_match_rt = 1'b1;
      end
    end
  end

  assign o_hazard = (i_use_rs & w_match_rs) | (i_use_rt & w_match_rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / mispredict control: stalls fetch on a read-after-write
// hazard, flushes decode on hazards and mispredicts, and extends a mispredict
// flush to FLUSHLEN cycles through the RECOVER state.
// Optional feature: define PIPE_PERF_EN to add 32-bit stallcnt / flushcnt.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REGNOBITS = REGNOBITS_DEF,
  parameter int SBDEPTH   = 2,
  parameter int FLUSHLEN  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 isnop_D,
  input  logic [REGNOBITS-1:0] rs_D,
  input  logic [REGNOBITS-1:0] rt_D,
  input  logic                 usert_D,
  input  logic                 wrreg_D,
  input  logic [REGNOBITS-1:0] wregno_D,
  input  logic                 mispred_B,
  output logic                 stall_F,
  output logic                 flush_D,
  output logic                 busy
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]          stallcnt,
  output logic [31:0]          flushcnt
`endif
);

  localparam logic [2:0] RELOAD = 3'(FLUSHLEN - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       w_hazard;
  logic       w_ins_valid;

  // A flushed or bubble instruction never claims a destination register.
  assign w_ins_valid = wrreg_D & ~isnop_D & ~flush_D;

  pipe_scoreboard #(
    .REGNOBITS (REGNOBITS),
    .SBDEPTH   (SBDEPTH)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_ins_valid (w_ins_valid),
    .i_wregno    (wregno_D),
    .i_use_rs    (~isnop_D),
    .i_rs        (rs_D),
    .i_use_rt    (usert_D),
    .i_rt        (rt_D),
    .o_hazard    (w_hazard),
    .o_busy      (busy)
  );

  // Reset forces a flush combinationally; a mispredict overrides a stall.
  assign flush_D = reset | mispred_B | (r_state == RECOVER) | w_hazard;
  assign stall_F = w_hazard & ~mispred_B & (r_state == RUN);

  // FSM state and recovery counter; async reset aborts recovery at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: enter/extend recovery on mispredict, count down to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (mispred_B && FLUSHLEN > 1) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = RELOAD;
        end
      end
      RECOVER: begin
        if (mispred_B) begin
          w_cnt_nxt = RELOAD;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PIPE_PERF_EN
  logic [31:0] r_stallcnt;
  logic [31:0] r_flushcnt;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallcnt <= '0;
      r_flushcnt <= '0;
    end else begin
      if (stall_F)   r_stallcnt <= r_stallcnt + 32'd1;
      if (mispred_B) r_flushcnt <= r_flushcnt + 32'd1;
    end
  end

  assign stallcnt = r_stallcnt;
  assign flushcnt = r_flushcnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (REGNOBITS=6, SBDEPTH=2, FLUSHLEN=3).
// Stimulus pushes the hand-computed {stall_F, flush_D, busy} for each cycle;
// a monitor pops and compares at every falling edge.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       isnop_D;
  logic [5:0] rs_D;
  logic [5:0] rt_D;
  logic       usert_D;
  logic       wrreg_D;
  logic [5:0] wregno_D;
  logic       mispred_B;
  logic       stall_F;
  logic       flush_D;
  logic       busy;
`ifdef PIPE_PERF_EN
  logic [31:0] stallcnt;
  logic [31:0] flushcnt;
`endif

  pipe_ctrl #(
    .REGNOBITS (6),
    .SBDEPTH   (2),
    .FLUSHLEN  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .isnop_D   (isnop_D),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .usert_D   (usert_D),
    .wrreg_D   (wrreg_D),
    .wregno_D  (wregno_D),
    .mispred_B (mispred_B),
    .stall_F   (stall_F),
    .flush_D   (flush_D),
    .busy      (busy)
`ifdef PIPE_PERF_EN
    ,
    .stallcnt  (stallcnt),
    .flushcnt  (flushcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  stall;
    logic  flush;
    logic  busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compare the oldest expectation mid-cycle, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.name, " stall_F"}, 32'(stall_F), 32'(e.stall));
      check({e.name, " flush_D"}, 32'(flush_D), 32'(e.flush));
      check({e.name, " busy"},    32'(busy),    32'(e.busy));
    end
  end

  task automatic apply(input string name, input logic nop, input logic [5:0] rs,
                       input logic [5:0] rt, input logic ut, input logic wr,
                       input logic [5:0] wn, input logic mp,
                       input logic es, input logic ef, input logic eb);
    isnop_D   = nop;
    rs_D      = rs;
    rt_D      = rt;
    usert_D   = ut;
    wrreg_D   = wr;
    wregno_D  = wn;
    mispred_B = mp;
    exp_q.push_back('{name, es, ef, eb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic nop, input logic [5:0] rs,
                      input logic [5:0] rt, input logic ut, input logic wr,
                      input logic [5:0] wn, input logic mp,
                      input logic es, input logic ef, input logic eb);
    apply(name, nop, rs, rt, ut, wr, wn, mp, es, ef, eb);
    tick();
  endtask

  // Bubble cycle, optionally with a mispredict.
  task automatic idle(input string name, input logic mp,
                      input logic es, input logic ef, input logic eb);
    step(name, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, mp, es, ef, eb);
  endtask

  initial begin
    reset     = 1'b1;
    isnop_D   = 1'b1;
    rs_D      = '0;
    rt_D      = '0;
    usert_D   = 1'b0;
    wrreg_D   = 1'b0;
    wregno_D  = '0;
    mispred_B = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    idle("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back dependency: producer r5, consumer rs=5 stalls 2 cycles.
    step("b2b_prod", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("b2b_c1",   1'b0, 6'd5, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("b2b_c2",   1'b0, 6'd5, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("b2b_c3",   1'b0, 6'd5, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("b2b_done", 1'b0, 1'b0, 1'b0, 1'b0);

    // rt=7 not read: no stall, but the write is still in flight.
    step("rt_off_prod", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rt_off_use",  1'b0, 6'd0, 6'd7, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("rt_off_i1", 1'b0, 1'b0, 1'b0, 1'b1);
    idle("rt_off_i2", 1'b0, 1'b0, 1'b0, 1'b0);
    // rt=7 read: 2-cycle stall.
    step("rt_on_prod", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rt_on_c1",   1'b0, 6'd0, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("rt_on_c2",   1'b0, 6'd0, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("rt_on_c3",   1'b0, 6'd0, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mispredict beats hazard; the r12 write of that cycle must not enter.
    step("mp_prod", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd9,  1'b0, 1'b0, 1'b0, 1'b0);
    step("mp_haz",  1'b0, 6'd9, 6'd0, 1'b0, 1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 1'b1);
    idle("mp_rec1", 1'b0, 1'b0, 1'b1, 1'b1);
    idle("mp_rec2", 1'b0, 1'b0, 1'b1, 1'b0);
    idle("mp_run",  1'b0, 1'b0, 1'b0, 1'b0);

    // Single mispredict: flush exactly 3 cycles.
    idle("rec_a", 1'b1, 1'b0, 1'b1, 1'b0);
    idle("rec_b", 1'b0, 1'b0, 1'b1, 1'b0);
    idle("rec_c", 1'b0, 1'b0, 1'b1, 1'b0);
    idle("rec_d", 1'b0, 1'b0, 1'b0, 1'b0);
    // Second pulse in the 2nd flush cycle: flush 4 cycles.
    idle("ext_a", 1'b1, 1'b0, 1'b1, 1'b0);
    idle("ext_b", 1'b1, 1'b0, 1'b1, 1'b0);
    idle("ext_c", 1'b0, 1'b0, 1'b1, 1'b0);
    idle("ext_d", 1'b0, 1'b0, 1'b1, 1'b0);
    idle("ext_e", 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset while busy and in RECOVER, checked before the next edge.
    step("rst_prod", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("rst_mp", 1'b1, 1'b0, 1'b1, 1'b1);
    apply("rst_async", 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
    // First instruction after reset: reads r3, writes r4, no stall.
    step("rst_first", 1'b0, 6'd3, 6'd0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three stall cycles and two mispredicts since reset.
    step("pc_c1",  1'b0, 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("pc_c2",  1'b0, 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("pc_c3",  1'b0, 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pc_p6",  1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("pc_gap", 1'b0, 1'b0, 1'b0, 1'b1);
    step("pc_old", 1'b0, 6'd6, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("pc_clr", 1'b0, 6'd6, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("pc_m1",  1'b1, 1'b0, 1'b1, 1'b0);
    idle("pc_m2",  1'b1, 1'b0, 1'b1, 1'b0);
    idle("pc_r1",  1'b0, 1'b0, 1'b1, 1'b0);
    idle("pc_r2",  1'b0, 1'b0, 1'b1, 1'b0);
    idle("pc_run", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_EN
    check("stallcnt", stallcnt, 32'd3);
    check("flushcnt", flushcnt, 32'd2);
`endif

    // One more single-cycle stall; with counters, it wraps a preloaded max.
    step("wr_prod", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("wr_gap", 1'b0, 1'b0, 1'b0, 1'b1);
    apply("wr_stall", 1'b0, 6'd8, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef PIPE_PERF_EN
    #2 dut.r_stallcnt = 32'hFFFF_FFFF;
`endif
    tick();
    step("wr_clr", 1'b0, 6'd8, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_EN
    check("stallcnt_wrap", stallcnt, 32'd0);
    check("flushcnt_hold", flushcnt, 32'd2);
`endif

    // Let the monitor drain, bounded.
    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
